cam_req_sequencer: RTL

Request front-end placed directly upstream of the CAM controller. Accepts read/write requests over a valid/ready handshake and buffers them in a small in-order FIFO. Issues at most one single-cycle read or write strobe per clock to the CAM, then registers read results into a held response channel.

---
 rtl/cam_req_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cam_req_sequencer.sv
// Request front-end for the CAM controller: in-order request FIFO, one strobe per cycle, held read response.
// Latency: a request issues no earlier than the cycle after it is accepted; read response is registered one cycle after the strobe.
// Backpressure: req_ready_o = !full (registered state only); a read head waits while the response slot is occupied.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid_i/req_ready_o          request handshake; req_write_i, req_key_i, req_val_i carry the request
//   cam_read_o/cam_write_o           single-cycle strobes to the CAM with cam_key_o, cam_val_o
//   cam_hit_i, cam_rdata_i           CAM read result, valid in the same cycle as cam_read_o
//   rsp_valid_o/rsp_ready_i          held read response with rsp_hit_o, rsp_val_o (0 on miss)
//   stat_hits_o, stat_misses_o, stat_writes_o   saturating event counters, present only when CAM_SEQ_STATS_EN is defined
module cam_req_sequencer #(
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [KEY_WIDTH-1:0] req_key_i,
    input  logic [VAL_WIDTH-1:0] req_val_i,
    output logic                 cam_read_o,
    output logic                 cam_write_o,
    output logic [KEY_WIDTH-1:0] cam_key_o,
    output logic [VAL_WIDTH-1:0] cam_val_o,
    input  logic                 cam_hit_i,
    input  logic [VAL_WIDTH-1:0] cam_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [VAL_WIDTH-1:0] rsp_val_o
`ifdef CAM_SEQ_STATS_EN
    ,
    output logic [15:0]          stat_hits_o,
    output logic [15:0]          stat_misses_o,
    output logic [15:0]          stat_writes_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t               state;
    state_t               state_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 last;
    logic                 slot_free;

    logic                 mem_wr  [DEPTH];
    logic [KEY_WIDTH-1:0] mem_key [DEPTH];
    logic [VAL_WIDTH-1:0] mem_val [DEPTH];

    logic                 head_wr;
    logic [KEY_WIDTH-1:0] head_key;
    logic [VAL_WIDTH-1:0] head_val;

    assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count       = wptr - rptr;
    assign last        = (count == (AW+1)'(1));
    assign req_ready_o = !full;
    assign push        = req_valid_i && !full;
    assign slot_free   = !rsp_valid_o || rsp_ready_i;

    assign head_wr     = mem_wr[rptr[AW-1:0]];
    assign head_key    = mem_key[rptr[AW-1:0]];
    assign head_val    = mem_val[rptr[AW-1:0]];

    // Payload storage needs no reset: it is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_wr[wptr[AW-1:0]]  <= req_write_i;
            mem_key[wptr[AW-1:0]] <= req_key_i;
            mem_val[wptr[AW-1:0]] <= req_val_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            state <= IDLE;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cam_read_o  = 1'b0;
        cam_write_o = 1'b0;
        cam_key_o   = '0;
        cam_val_o   = '0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (push) state_nxt = RUN;
            end
            RUN: begin
                cam_key_o = head_key;
                cam_val_o = head_val;
                if (head_wr) begin
                    cam_write_o = 1'b1;
                    pop         = 1'b1;
                end else if (slot_free) begin
                    cam_read_o = 1'b1;
                    pop        = 1'b1;
                end else begin
                    state_nxt = STALL;
                end
                // Draining the last entry with nothing arriving behind it.
                if (pop && last && !push) state_nxt = IDLE;
            end
            STALL: begin
                // Re-issue from RUN once the held response has been taken.
                if (slot_free) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A capture on the same edge as a handshake replaces the held response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_val_o   <= '0;
        end else if (cam_read_o) begin
            rsp_valid_o <= 1'b1;
            rsp_hit_o   <= cam_hit_i;
            rsp_val_o   <= cam_hit_i ? cam_rdata_i : '0;
        end else if (rsp_valid_o && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

`ifdef CAM_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
            stat_writes_o <= '0;
        end else begin
            if (cam_read_o && cam_hit_i && (stat_hits_o != 16'hFFFF))
                stat_hits_o <= stat_hits_o + 16'd1;
            if (cam_read_o && !cam_hit_i && (stat_misses_o != 16'hFFFF))
                stat_misses_o <= stat_misses_o + 16'd1;
            if (cam_write_o && (stat_writes_o != 16'hFFFF))
                stat_writes_o <= stat_writes_o + 16'd1;
        end
    end
`endif

endmodule
